water_level_ctrl: RTL
=====================

// Module: water_level_ctrl
// PURPOSE
//  Closed-loop controller for the bakery water tank; the controller side of the Water plant interface.
//  Reads the tank level sensors (base/middle/top) and S_pressure_high.
//  Drives the X_water, X_drain and X_dispenser actuators.
//  Executes fill, dispense, drain and abort commands from the recipe sequencer over a valid/ready handshake.
//  Enforces actuator interlocks and a fill timeout.
// PARAMETERS
//  FILL_TIMEOUT  64  max en-ticks in FILL before FAULT (plant fills empty->top in ~34 ticks)
//  DRAIN_TAIL    4   extra en-ticks of X_drain after Y_water_base falls
//  TW            8   width of timeout/tail counter
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  en              in   1   simulation tick enable; timers count only when en=1
//  cmd_valid       in   1   command present
//  cmd_ready       out  1   controller accepts command this cycle
//  cmd_op          in   2   00 FILL, 01 DISPENSE, 10 DRAIN, 11 ABORT
//  cmd_len         in   8   DISPENSE length in en-ticks (0 = no-op)
//  Y_water_base    in   1   level > base sensor
//  Y_water_middle  in   1   level > middle sensor
//  Y_water_top     in   1   level > top sensor
//  S_pressure_high in   1   line pressure high
//  X_water         out  1   inlet valve
//  X_drain         out  1   drain valve
//  X_dispenser     out  1   dispenser valve
//  busy            out  1   state not IDLE/READY/FAULT
//  done            out  1   1-cycle pulse on command completion
//  fault           out  1   high while in FAULT
//  underrun        out  1   sticky: dispense cut short by empty tank; cleared on next accepted cmd
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except cmd_ready=1; counters 0.
//  States: IDLE, FILL, READY, DISPENSE, DRAIN, FAULT. Outputs are registered, one clk after the state change.
//  Handshake: transfer when cmd_valid&&cmd_ready.
//  - cmd_ready=1 in IDLE and READY for any op.
//  - In FILL/DISPENSE/DRAIN/FAULT, cmd_ready=1 only while cmd_op==ABORT.
//  Command dispatch:
//  - FILL: if Y_water_top already 1 -> READY + done; else go to FILL.
//  - FILL state: X_water=1; counter +1 per en.
//    - Y_water_top=1 -> READY + done.
//    - counter reaches FILL_TIMEOUT first -> FAULT.
//  - DISPENSE: len=0 -> done, state unchanged.
//    - Y_water_base=0 -> underrun=1 + done, state unchanged.
//    - Otherwise load len into the counter and enter DISPENSE.
//  - DISPENSE state: X_dispenser = S_pressure_high && Y_water_base.
//    - Counter decrements only on en with S_pressure_high=1; pressure loss pauses the count.
//    - Counter hits 0 -> READY + done.
//    - Y_water_base falls -> underrun=1, DRAIN skipped, IDLE + done.
//  - DRAIN state: X_drain=1 until Y_water_base=0, then DRAIN_TAIL more en-ticks -> IDLE + done.
//  - ABORT: all actuators 0 next clk; state IDLE + done from any state, including FAULT.
//    - ABORT is the only exit from FAULT.
//  Interlocks, hold every cycle:
//  - X_water & X_drain never both 1.
//  - X_dispenser never 1 with X_drain.
//  - All X_* = 0 in IDLE, READY and FAULT (unless the auto-refill option below is active).
//  Simultaneous events:
//  - ABORT beats every internal completion/timeout in the same cycle; done pulses once.
//  - Timeout and top reached on the same en -> READY (success wins).
//  Counters saturate; never wrap. rst_n low mid-operation closes all valves asynchronously.
// CONFIGURATION
//  WATER_CTRL_AUTOREFILL_EN defined:
//  - In READY, Y_water_middle=0 -> re-enter FILL without a command; no done pulse on that refill's completion.
//  - Fill timeout and FAULT still apply.
//  - cmd_ready=0 during auto FILL except for ABORT.
//  Undefined: READY is passive; level may decay to any value with no action.
// TESTING
//  Empty tank, FILL, en every clk, plant +1500/tick -> X_water 1 for ~34 ticks; Y_top; READY; one done; X_water 0.
//  FILL with Y_water_top stuck 0, en every clk -> FAULT after 64 ticks.
//  - In FAULT: X_* all 0; cmd_ready=0 for op FILL; ABORT -> IDLE + done.
//  READY, DISPENSE len=10, pressure toggling 1/0 each tick.
//  - X_dispenser follows pressure; done after 10 high ticks (20 total); state READY.
//  DISPENSE len=200 from just-full tank -> Y_base falls -> underrun=1, IDLE, done; next FILL clears underrun.
//  DRAIN from full tank -> X_drain until Y_base=0, plus 4 ticks -> IDLE + done.
//  - ABORT issued mid-DRAIN in a second run -> X_drain 0 next clk.
//  AUTOREFILL_EN: READY, force Y_middle 0 -> FILL within 1 clk.
//  - AUTOREFILL_EN undefined, same stimulus -> stays READY, X_water 0.

Source files
------------

// File: rtl/water_level_if.sv
// water_level_if: recipe-sequencer command channel, valid/ready with op and dispense length.
interface water_level_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/water_level_ctrl.sv
// water_level_ctrl: bakery water tank fill/dispense/drain/abort controller with interlocks and fill timeout.
// Optional WATER_CTRL_AUTOREFILL_EN: READY refills on its own when the middle sensor drops.
module water_level_ctrl #(
  parameter int FILL_TIMEOUT = 64,
  parameter int DRAIN_TAIL   = 4,
  parameter int TW           = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  water_level_if.slave cmd,
  input  logic         Y_water_base,
  input  logic         Y_water_middle,
  input  logic         Y_water_top,
  input  logic         S_pressure_high,
  output logic         X_water,
  output logic         X_drain,
  output logic         X_dispenser,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic         underrun
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_READY = 3'd2, S_DISP = 3'd3, S_DRAIN = 3'd4, S_FAULT = 3'd5;
  localparam logic [1:0] OP_FILL = 2'd0, OP_DISP = 2'd1, OP_ABORT = 2'd3;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic          auto_q, auto_d, done_q, done_d, underrun_q, underrun_d, acc;
  logic          x_water_q, x_drain_q, x_disp_q, busy_q, fault_q;
  assign cmd.cmd_ready = state_q == S_IDLE || state_q == S_READY || cmd.cmd_op == OP_ABORT;
  assign acc           = cmd.cmd_valid && cmd.cmd_ready;
  assign cnt_inc       = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign cnt_dec       = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    auto_d     = auto_q;
    done_d     = 1'b0;
    underrun_d = acc ? 1'b0 : underrun_q;
    if (acc && cmd.cmd_op == OP_ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      auto_d  = 1'b0;
      done_d  = 1'b1;
    end else if (acc) begin
      cnt_d  = '0;
      auto_d = 1'b0;
      if (cmd.cmd_op == OP_FILL) begin
        state_d = Y_water_top ? S_READY : S_FILL;
        done_d  = Y_water_top;
      end else if (cmd.cmd_op == OP_DISP) begin
        // zero length or empty tank completes on the spot without leaving the current state
        if (cmd.cmd_len == '0 || !Y_water_base) begin
          done_d     = 1'b1;
          underrun_d = cmd.cmd_len != '0;
        end else begin
          state_d = S_DISP;
          cnt_d   = TW'(cmd.cmd_len);
        end
      end else begin
        state_d = S_DRAIN;
      end
    end else begin
      case (state_q)
        S_FILL:
          if (Y_water_top) begin
            state_d = S_READY;
            done_d  = !auto_q;
            auto_d  = 1'b0;
          end else if (en) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= TW'(FILL_TIMEOUT)) begin
              state_d = S_FAULT;
              auto_d  = 1'b0;
            end
          end
        S_DISP:
          if (!Y_water_base) begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
            done_d     = 1'b1;
          end else if (en && S_pressure_high) begin
            cnt_d = cnt_dec;
            if (cnt_q <= TW'(1)) begin
              state_d = S_READY;
              done_d  = 1'b1;
            end
          end
        // the tail only counts while the tank reads empty; a refilling inlet restarts it
        S_DRAIN:
          if (Y_water_base) cnt_d = '0;
          else if (en) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= TW'(DRAIN_TAIL)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
`ifdef WATER_CTRL_AUTOREFILL_EN
        S_READY:
          if (!Y_water_middle) begin
            state_d = S_FILL;
            cnt_d   = '0;
            auto_d  = 1'b1;
          end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      auto_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      x_water_q  <= 1'b0;
      x_drain_q  <= 1'b0;
      x_disp_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      x_water_q  <= state_d == S_FILL;
      x_drain_q  <= state_d == S_DRAIN;
      x_disp_q   <= state_d == S_DISP && S_pressure_high && Y_water_base;
      busy_q     <= state_d == S_FILL || state_d == S_DISP || state_d == S_DRAIN;
      fault_q    <= state_d == S_FAULT;
    end
  assign X_water     = x_water_q;
  assign X_drain     = x_drain_q;
  assign X_dispenser = x_disp_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign underrun    = underrun_q;
endmodule
